axis_tx_frame_fifo: RTL and testbench
=====================================

// Module: axis_tx_frame_fifo
// PURPOSE
//  Store-and-forward TX frame FIFO sitting directly upstream of the AXIS->XGMII encoder.
//  Releases a frame only once its last beat is stored, so the encoder never sees a
//  mid-frame tvalid gap (which it would encode as an error/abort).
//  Drops errored frames (tuser on last) and frames that overflow the buffer.
// PARAMETERS
//  DEPTH_LOG2    9   log2 of buffer entries (64b beats); usable capacity 2**DEPTH_LOG2-1
//  DROP_ERRORED  1   1: discard frames whose last beat has tuser=1; 0: forward, tuser on last
// PORTS
//  clock           in   1   single clock domain
//  aresetn         in   1   asynchronous, active-low reset
//  saxis_tdata     in   64  upstream frame data, byte 0 = [7:0]
//  saxis_tkeep     in   8   contiguous-from-LSB byte enables (all ones except on last)
//  saxis_tvalid    in   1   upstream beat valid
//  saxis_tready    out  1   FIFO accepts beat
//  saxis_tlast     in   1   last beat of frame
//  saxis_tuser     in   1   frame error, sampled with tlast
//  maxis_tdata     out  64  to encoder
//  maxis_tkeep     out  8
//  maxis_tvalid    out  1
//  maxis_tready    in   1   encoder ready; deasserts for 1 cycle after each accepted tlast
//  maxis_tlast     out  1
//  maxis_tuser     out  1   0 when DROP_ERRORED=1
//  drop_count      out  32  frames discarded since reset, saturating at 32'hFFFF_FFFF
//  overflow        out  1   1-cycle pulse when a frame is dropped for lack of space
// BEHAVIOUR
//  Reset: all pointers 0; saxis_tready=0, maxis_tvalid/tlast/tuser=0, maxis_tdata/tkeep=0,
//   drop_count=0, overflow=0. saxis_tready rises on the first edge after reset release.
//  Pointers DEPTH_LOG2+1 bits: wr_ptr, wr_commit, rd_ptr. Full when wr_ptr-rd_ptr==2**DEPTH_LOG2-1.
//  Write FSM states: IDLE, STORE, DISCARD.
//   IDLE/STORE: saxis_tready=1; each accepted beat written at wr_ptr (data,keep,last,user), wr_ptr++.
//    IDLE->STORE on accepted non-last beat; single-beat frame commits directly.
//   Accepted tlast, tuser=0 (or DROP_ERRORED=0): wr_commit<=wr_ptr+1; ->IDLE.
//   Accepted tlast, tuser=1, DROP_ERRORED=1: wr_ptr<=wr_commit (rewind); drop_count++; ->IDLE.
//   Beat offered while full: beat not stored, wr_ptr<=wr_commit, overflow=1, drop_count++;
//    ->DISCARD unless that beat has tlast (then ->IDLE).
//   DISCARD: saxis_tready=1, beats sunk without write; accepted tlast ->IDLE.
//  Full test uses rd_ptr as of the current cycle; a simultaneous read freeing space does not
//   prevent the drop (conservative, deterministic).
//  Read side: frame available when rd_ptr!=wr_commit. RAM read is registered (1 cycle);
//   2-entry output skid buffer prefetches so maxis_tvalid stays high through maxis_tready stalls.
//  Latency: empty FIFO, tlast accepted at edge N -> maxis_tvalid high after edge N+3.
//  Once maxis_tvalid rises for a frame's first beat, it stays high until its tlast is accepted;
//   the next committed frame may follow back-to-back (tvalid held through the tready gap).
//  maxis_* payload stable while tvalid && !tready (AXIS rule).
//  Frames longer than capacity always overflow and are dropped; no deadlock.
//  Reset mid-frame: partial input and output frames lost; outputs return to reset values at once.
// STRUCTURE
//  Shared header xgmii_axis_defs.vh: AXIS_DATA_W=64, AXIS_KEEP_W=8 (also used by encoder/decoder).
//  Sub-module tx_fifo_ram: simple dual-port RAM, width 74 (data,keep,last,user), depth
//   2**DEPTH_LOG2, registered read port, no reset on array.
//  Top: write FSM, pointer/commit logic, prefetch+skid output stage, drop counter.
// TESTING
//  1 8-beat frame, last tkeep=8'h0F, maxis_tready=1 -> identical 8 beats out, tvalid first
//    high 3 cycles after input tlast edge, contiguous, tlast/tkeep=8'h0F on beat 8.
//  2 Frame A with tuser=1 on last, then good frame B -> only B emerges; drop_count=1, overflow=0.
//  3 DEPTH_LOG2=4, maxis_tready=0, 20-beat frame then 4-beat frame -> overflow pulses once,
//    drop_count=1; after tready=1 only the 4-beat frame emerges.
//  4 Five back-to-back 3-beat frames, maxis_tready modelling encoder (0 one cycle after each
//    tlast) -> all 15 beats in order, tvalid never low inside a frame.
//  5 Random maxis_tready stalls (50%) over 200 random-length frames -> scoreboard exact match,
//    payload stable while stalled.
//  6 aresetn low mid-output of frame 2 -> outputs at reset values asynchronously; after release
//    new frame passes, drop_count=0.

Source files
------------

// File: rtl/axis_tx_frame_fifo_pkg.sv
// Shared types for the TX store-and-forward frame FIFO.
package axis_tx_frame_fifo_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  // One stored beat: payload plus framing sideband.
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
    logic                   user;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_STORE   = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_e;

endpackage

// File: rtl/tx_fifo_ram.sv
// Simple dual-port beat buffer with a registered read port; array is not reset.
module tx_fifo_ram
  import axis_tx_frame_fifo_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  beat_t         wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output beat_t         rdata_o
);

  beat_t mem_q [2**AW];

  // Write port.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port; data valid the cycle after re_i.
  always_ff @(posedge clock) begin
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/axis_tx_frame_fifo.sv
// Store-and-forward TX frame FIFO: a frame is released only once its last beat is
// stored, so the downstream encoder never sees a mid-frame tvalid gap. Errored and
// oversize frames are dropped by rewinding the write pointer to the last commit.
module axis_tx_frame_fifo
  import axis_tx_frame_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2   = 9,
  parameter bit DROP_ERRORED = 1'b1
) (
  input  logic                   clock,
  input  logic                   aresetn,
  input  logic [AXIS_DATA_W-1:0] saxis_tdata,
  input  logic [AXIS_KEEP_W-1:0] saxis_tkeep,
  input  logic                   saxis_tvalid,
  output logic                   saxis_tready,
  input  logic                   saxis_tlast,
  input  logic                   saxis_tuser,
  output logic [AXIS_DATA_W-1:0] maxis_tdata,
  output logic [AXIS_KEEP_W-1:0] maxis_tkeep,
  output logic                   maxis_tvalid,
  input  logic                   maxis_tready,
  output logic                   maxis_tlast,
  output logic                   maxis_tuser,
  output logic [31:0]            drop_count,
  output logic                   overflow
);

  localparam int             PW  = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0]  CAP = PW'(2**DEPTH_LOG2 - 1);

  wr_state_e      st_q, st_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, commit_q, commit_d, commit_rd_q, rd_ptr_q;
  logic           rdy_q, ovf_q, ovf_d, drop_ev, acc, full, we, re, pop, push;
  logic [31:0]    drop_q;
  logic [1:0]     occ_q;
  logic           pend_q;
  logic [2:0]     fill;
  beat_t          wbeat, ram_q, ent0_q, ent1_q;

  assign acc   = saxis_tvalid & rdy_q;
  // Occupancy counts the uncommitted frame in flight, so an oversize frame trips this.
  assign full  = (wr_ptr_q - rd_ptr_q) == CAP;
  assign wbeat = '{data: saxis_tdata, keep: saxis_tkeep, last: saxis_tlast, user: saxis_tuser};

  // Write FSM: store, commit on good tlast, rewind on error or overflow.
  always_comb begin
    st_d     = st_q;
    wr_ptr_d = wr_ptr_q;
    commit_d = commit_q;
    we       = 1'b0;
    ovf_d    = 1'b0;
    drop_ev  = 1'b0;
    unique case (st_q)
      WR_IDLE, WR_STORE: begin
        if (acc) begin
          if (full) begin
            wr_ptr_d = commit_q;
            ovf_d    = 1'b1;
            drop_ev  = 1'b1;
            st_d     = saxis_tlast ? WR_IDLE : WR_DISCARD;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (!saxis_tlast) begin
              st_d = WR_STORE;
            end else if (saxis_tuser && DROP_ERRORED) begin
              wr_ptr_d = commit_q;
              drop_ev  = 1'b1;
              st_d     = WR_IDLE;
            end else begin
              commit_d = wr_ptr_q + 1'b1;
              st_d     = WR_IDLE;
            end
          end
        end
      end
      WR_DISCARD: if (acc && saxis_tlast) st_d = WR_IDLE;
      default:    st_d = WR_IDLE;
    endcase
  end

  // Write-side state, pointers, drop counter and overflow pulse.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      st_q        <= WR_IDLE;
      wr_ptr_q    <= '0;
      commit_q    <= '0;
      commit_rd_q <= '0;
      rdy_q       <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      st_q        <= st_d;
      wr_ptr_q    <= wr_ptr_d;
      commit_q    <= commit_d;
      commit_rd_q <= commit_q;
      rdy_q       <= 1'b1;
      ovf_q       <= ovf_d;
      if (drop_ev && drop_q != 32'hFFFF_FFFF) drop_q <= drop_q + 32'd1;
    end
  end

  tx_fifo_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clock   (clock),
    .we_i    (we),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (wbeat),
    .re_i    (re),
    .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rdata_o (ram_q)
  );

  // Prefetch: keep skid entries plus the in-flight RAM read at or below two.
  assign pop  = (occ_q != 2'd0) & maxis_tready;
  assign push = pend_q;
  assign fill = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
  assign re   = (rd_ptr_q != commit_rd_q) && (fill < 3'd2);

  // Read pointer, RAM-read pending flag and the 2-entry output skid.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr_q <= '0;
      pend_q   <= 1'b0;
      occ_q    <= 2'd0;
      ent0_q   <= '0;
      ent1_q   <= '0;
    end else begin
      if (re) rd_ptr_q <= rd_ptr_q + 1'b1;
      pend_q <= re;
      unique case (occ_q)
        2'd0: if (push) begin
          ent0_q <= ram_q;
          occ_q  <= 2'd1;
        end
        2'd1: begin
          if (pop && push) ent0_q <= ram_q;
          else if (pop) occ_q <= 2'd0;
          else if (push) begin
            ent1_q <= ram_q;
            occ_q  <= 2'd2;
          end
        end
        default: if (pop) begin
          ent0_q <= ent1_q;
          if (push) ent1_q <= ram_q;
          else occ_q <= 2'd1;
        end
      endcase
    end
  end

  assign saxis_tready = rdy_q;
  assign maxis_tvalid = occ_q != 2'd0;
  assign maxis_tdata  = ent0_q.data;
  assign maxis_tkeep  = ent0_q.keep;
  assign maxis_tlast  = maxis_tvalid & ent0_q.last;
  assign maxis_tuser  = DROP_ERRORED ? 1'b0 : (maxis_tvalid & ent0_q.user);
  assign drop_count   = drop_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_axis_tx_frame_fifo.sv
// Directed bench for the TX frame FIFO (small 16-entry instance).
module tb_axis_tx_frame_fifo;

  typedef logic [79:0] v_t;

  logic        clock = 1'b0;
  logic        aresetn = 1'b1;
  logic [63:0] saxis_tdata;
  logic [7:0]  saxis_tkeep;
  logic        saxis_tvalid, saxis_tready, saxis_tlast, saxis_tuser;
  logic [63:0] maxis_tdata;
  logic [7:0]  maxis_tkeep;
  logic        maxis_tvalid, maxis_tlast, maxis_tuser;
  logic        maxis_tready = 1'b0;
  logic [31:0] drop_count;
  logic        overflow;

  int          n_chk = 0, n_err = 0;
  logic [72:0] exp_mem [0:4095];
  int          wr_idx = 0, rd_idx = 0;
  int          rdy_mode = 0, out_cnt = 0, ovf_cnt = 0, cyc = 0, start_cyc = 0, span = -1;
  bit          hs_last = 0, in_frame = 0, prev_stall = 0;
  logic [72:0] prev_beat;

  always #5 clock = ~clock;

  axis_tx_frame_fifo #(.DEPTH_LOG2(4), .DROP_ERRORED(1'b1)) dut (
    .clock        (clock),
    .aresetn      (aresetn),
    .saxis_tdata  (saxis_tdata),
    .saxis_tkeep  (saxis_tkeep),
    .saxis_tvalid (saxis_tvalid),
    .saxis_tready (saxis_tready),
    .saxis_tlast  (saxis_tlast),
    .saxis_tuser  (saxis_tuser),
    .maxis_tdata  (maxis_tdata),
    .maxis_tkeep  (maxis_tkeep),
    .maxis_tvalid (maxis_tvalid),
    .maxis_tready (maxis_tready),
    .maxis_tlast  (maxis_tlast),
    .maxis_tuser  (maxis_tuser),
    .drop_count   (drop_count),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input v_t got, input v_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard, stall stability, in-frame tvalid, overflow pulses.
  task automatic monitor();
    logic [72:0] cur;
    bit hs;
    forever begin
      @(negedge clock);
      cyc++;
      if (!aresetn) begin
        in_frame = 0; prev_stall = 0; hs_last = 0; rd_idx = wr_idx;
      end else begin
        cur = {maxis_tlast, maxis_tkeep, maxis_tdata};
        if (prev_stall) chk("stall_hold", v_t'({maxis_tvalid, cur}), v_t'({1'b1, prev_beat}));
        if (in_frame) chk("inframe_vld", v_t'(maxis_tvalid), v_t'(1));
        if (overflow) ovf_cnt++;
        hs = maxis_tvalid && maxis_tready;
        if (hs) begin
          chk("beat_pending", v_t'(wr_idx != rd_idx), v_t'(1));
          if (wr_idx != rd_idx) begin
            chk("beat", v_t'(cur), v_t'(exp_mem[rd_idx]));
            rd_idx++;
          end
          chk("tuser", v_t'(maxis_tuser), v_t'(0));
          if (!in_frame) start_cyc = cyc;
          out_cnt++;
          in_frame = !maxis_tlast;
          if (maxis_tlast) span = cyc - start_cyc;
        end
        hs_last    = hs && maxis_tlast;
        prev_stall = maxis_tvalid && !maxis_tready;
        prev_beat  = cur;
      end
    end
  endtask

  // Downstream ready: 0 always-on, 1 random, 2 encoder gap after tlast, 3 held low.
  task automatic rdy_drv();
    forever begin
      @(posedge clock); #1;
      case (rdy_mode)
        0:       maxis_tready = 1'b1;
        1:       maxis_tready = 1'($urandom_range(0, 1));
        2:       maxis_tready = !hs_last;
        default: maxis_tready = 1'b0;
      endcase
    end
  endtask

  task automatic sync();
    @(posedge clock); #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    int t = 0;
    saxis_tdata = d; saxis_tkeep = k; saxis_tlast = l; saxis_tuser = u; saxis_tvalid = 1'b1;
    @(negedge clock);
    while (!saxis_tready && t < 100) begin t++; @(negedge clock); end
    if (t >= 100) chk("in_rdy_timeout", v_t'(saxis_tready), v_t'(1));
    @(posedge clock); #1;
    saxis_tvalid = 1'b0; saxis_tlast = 1'b0; saxis_tuser = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] lk, input bit err, input bit keep_exp);
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      l = (i == len - 1);
      k = l ? lk : 8'hFF;
      if (keep_exp) begin exp_mem[wr_idx] = {l, k, d}; wr_idx++; end
      send_beat(d, k, l, err && l);
    end
  endtask

  task automatic wait_drain(input int max);
    int t = 0;
    while (wr_idx != rd_idx && t < max) begin @(negedge clock); t++; end
    if (wr_idx != rd_idx) chk("drain_timeout", v_t'(wr_idx - rd_idx), v_t'(0));
    repeat (4) @(negedge clock);
  endtask

  task automatic do_reset();
    @(posedge clock); #3; aresetn = 1'b0;
    repeat (3) @(posedge clock); #3; aresetn = 1'b1;
  endtask

  initial begin
    int k, o0, ovf0, total, len, t;
    saxis_tdata = '0; saxis_tkeep = '0; saxis_tvalid = 1'b0; saxis_tlast = 1'b0; saxis_tuser = 1'b0;
    #2 aresetn = 1'b0;
    fork
      monitor();
      rdy_drv();
      begin
        // reset state
        repeat (2) @(negedge clock);
        chk("rst_sready", v_t'(saxis_tready), v_t'(0));
        chk("rst_mvalid", v_t'(maxis_tvalid), v_t'(0));
        chk("rst_mlast",  v_t'(maxis_tlast), v_t'(0));
        chk("rst_mdata",  v_t'({maxis_tdata, maxis_tkeep}), v_t'(0));
        chk("rst_drop",   v_t'(drop_count), v_t'(0));
        chk("rst_ovf",    v_t'(overflow), v_t'(0));
        @(posedge clock); #3; aresetn = 1'b1;
        @(negedge clock);
        chk("rel_rdy0", v_t'(saxis_tready), v_t'(0));
        @(negedge clock);
        chk("rel_rdy1", v_t'(saxis_tready), v_t'(1));

        // 1: 8-beat frame, latency and contiguity
        sync();
        send_frame(8, 8'h0F, 0, 1);
        k = 0;
        do begin @(negedge clock); k++; end while (!maxis_tvalid && k < 20);
        chk("t1_latency", v_t'(k), v_t'(4));
        wait_drain(100);
        chk("t1_span", v_t'(span), v_t'(7));
        chk("t1_cnt", v_t'(out_cnt), v_t'(8));

        // 2: errored frame dropped, good frame passes
        sync();
        send_frame(3, 8'hFF, 1, 0);
        send_frame(4, 8'h03, 0, 1);
        wait_drain(100);
        chk("t2_drop", v_t'(drop_count), v_t'(1));
        chk("t2_ovf", v_t'(ovf_cnt), v_t'(0));
        chk("t2_cnt", v_t'(out_cnt), v_t'(12));

        // 3: oversize frame overflows while output is stalled
        do_reset();
        ovf0 = ovf_cnt; o0 = out_cnt;
        rdy_mode = 3;
        sync();
        send_frame(20, 8'hFF, 0, 0);
        send_frame(4, 8'h01, 0, 1);
        repeat (10) @(negedge clock);
        chk("t3_ovf", v_t'(ovf_cnt - ovf0), v_t'(1));
        chk("t3_drop", v_t'(drop_count), v_t'(1));
        chk("t3_held", v_t'(wr_idx - rd_idx), v_t'(4));
        chk("t3_vld", v_t'(maxis_tvalid), v_t'(1));
        rdy_mode = 0;
        wait_drain(100);
        chk("t3_cnt", v_t'(out_cnt - o0), v_t'(4));

        // 4: back-to-back frames into encoder-style ready
        rdy_mode = 2; o0 = out_cnt;
        sync();
        for (int f = 0; f < 5; f++) send_frame(3, 8'h7F, 0, 1);
        wait_drain(200);
        chk("t4_cnt", v_t'(out_cnt - o0), v_t'(15));

        // 5: random stalls, random frame lengths and last-beat keeps
        rdy_mode = 1; o0 = out_cnt; ovf0 = ovf_cnt; total = 0;
        sync();
        for (int f = 0; f < 200; f++) begin
          len = $urandom_range(1, 7);
          t = 0;
          while (wr_idx - rd_idx + len > 14 && t < 500) begin sync(); t++; end
          if (t >= 500) chk("t5_space_timeout", v_t'(wr_idx - rd_idx), v_t'(0));
          send_frame(len, 8'hFF >> $urandom_range(0, 7), 0, 1);
          total += len;
        end
        wait_drain(3000);
        chk("t5_cnt", v_t'(out_cnt - o0), v_t'(total));
        chk("t5_drop", v_t'(drop_count), v_t'(1));
        chk("t5_ovf", v_t'(ovf_cnt - ovf0), v_t'(0));

        // 6: asynchronous reset in the middle of frame 2's output
        rdy_mode = 0; o0 = out_cnt;
        sync();
        send_frame(3, 8'hFF, 0, 1);
        send_frame(6, 8'hFF, 0, 1);
        t = 0;
        while (out_cnt < o0 + 5 && t < 100) begin @(negedge clock); t++; end
        if (t >= 100) chk("t6_wait_timeout", v_t'(out_cnt - o0), v_t'(5));
        @(posedge clock); #3;
        chk("t6_pre_vld", v_t'(maxis_tvalid), v_t'(1));
        aresetn = 1'b0;
        #1;
        chk("t6_vld", v_t'(maxis_tvalid), v_t'(0));
        chk("t6_last", v_t'(maxis_tlast), v_t'(0));
        chk("t6_data", v_t'({maxis_tdata, maxis_tkeep}), v_t'(0));
        chk("t6_sready", v_t'(saxis_tready), v_t'(0));
        chk("t6_drop", v_t'(drop_count), v_t'(0));
        repeat (2) @(posedge clock); #3; aresetn = 1'b1;
        o0 = out_cnt;
        sync();
        send_frame(2, 8'h3F, 0, 1);
        wait_drain(100);
        chk("t6_cnt", v_t'(out_cnt - o0), v_t'(2));
        chk("t6_drop_post", v_t'(drop_count), v_t'(0));
      end
    join_any
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
